// File: rtl/ddr4_bank_arbiter_if.sv
// Avalon-MM burst bus shared by the arbiter's master-side and slave-side ports.
// The master modport is the view of the agent issuing commands.
interface ddr4_bank_arbiter_if #(
  parameter int unsigned ADDR_WIDTH  = 27,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned BURST_WIDTH = 7
);
  logic                      read;
  logic                      write;
  logic [ADDR_WIDTH-1:0]     address;
  logic [BURST_WIDTH-1:0]    burstcount;
  logic [DATA_WIDTH-1:0]     writedata;
  logic [DATA_WIDTH/8-1:0]   byteenable;
  logic                      waitrequest;
  logic [DATA_WIDTH-1:0]     readdata;
  logic                      readdatavalid;

  modport master (
    output read, write, address, burstcount, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, burstcount, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ddr4_bank_arbiter.sv
// Two-master round-robin arbiter for one DDR4 bank Avalon-MM port.
// Write bursts lock the grant; read returns are steered in order by a tag FIFO.
module ddr4_bank_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 27,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned BURST_WIDTH = 7,
  parameter int unsigned RDQ_DEPTH   = 64
) (
  input  logic                         Clk_200,
  input  logic                         SoftReset,
  ddr4_bank_arbiter_if.slave           m0,
  ddr4_bank_arbiter_if.slave           m1,
  ddr4_bank_arbiter_if.master          s,
  output logic [$clog2(RDQ_DEPTH):0]   rd_outstanding,
  output logic                         err_orphan_rdata
);

  localparam int unsigned PTR_W = $clog2(RDQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t                 state;
  logic                   prio;
  logic                   lock_id;
  logic [BURST_WIDTH-1:0] beats_left;

  logic                   full, empty, elig0, elig1;
  logic                   gnt_v, gnt_id;
  logic                   rd_sel, wr_sel;
  logic [ADDR_WIDTH-1:0]  addr_sel;
  logic [BURST_WIDTH-1:0] bc_sel;
  logic [DATA_WIDTH-1:0]  wdata_sel;
  logic [BE_W-1:0]        be_sel;
  logic                   cmd_rd, cmd_wr, accept, push, pop;

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [BURST_WIDTH-1:0] beat_cnt;
  logic                   beat_last, head_id;
  logic [BURST_WIDTH-1:0] head_bc;
  logic                   id_mem [RDQ_DEPTH];
  logic [BURST_WIDTH-1:0] bc_mem [RDQ_DEPTH];
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   rvalid0, rvalid1, orphan;

  // Grant selection: round-robin in IDLE, locked master only during a write burst.
  always_comb begin
    full   = (count == CNT_W'(RDQ_DEPTH));
    empty  = (count == '0);
    elig0  = m0.write | (m0.read & ~full);
    elig1  = m1.write | (m1.read & ~full);
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    if (state == IDLE) begin
      if (!prio) begin
        if (elig0)      begin gnt_v = 1'b1; gnt_id = 1'b0; end
        else if (elig1) begin gnt_v = 1'b1; gnt_id = 1'b1; end
      end else begin
        if (elig1)      begin gnt_v = 1'b1; gnt_id = 1'b1; end
        else if (elig0) begin gnt_v = 1'b1; gnt_id = 1'b0; end
      end
    end else begin
      gnt_id = lock_id;
      gnt_v  = lock_id ? m1.write : m0.write;
    end
  end

  // Command field mux toward the slave.
  always_comb begin
    rd_sel    = gnt_id ? m1.read       : m0.read;
    wr_sel    = gnt_id ? m1.write      : m0.write;
    addr_sel  = gnt_id ? m1.address    : m0.address;
    bc_sel    = gnt_id ? m1.burstcount : m0.burstcount;
    wdata_sel = gnt_id ? m1.writedata  : m0.writedata;
    be_sel    = gnt_id ? m1.byteenable : m0.byteenable;
    cmd_rd    = gnt_v & rd_sel & (state == IDLE);
    cmd_wr    = gnt_v & wr_sel;
    accept    = (cmd_rd | cmd_wr) & ~s.waitrequest;
    push      = accept & cmd_rd;
  end

  assign s.read         = cmd_rd;
  assign s.write        = cmd_wr;
  assign s.address      = addr_sel;
  assign s.burstcount   = bc_sel;
  assign s.writedata    = wdata_sel;
  assign s.byteenable   = be_sel;
  assign m0.waitrequest = (gnt_v && !gnt_id) ? s.waitrequest : 1'b1;
  assign m1.waitrequest = (gnt_v &&  gnt_id) ? s.waitrequest : 1'b1;

  // Arbitration state: pointer, burst lock and remaining write beats.
  always_ff @(posedge Clk_200) begin
    if (SoftReset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      lock_id    <= 1'b0;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_wr && bc_sel != BURST_WIDTH'(1)) begin
              state      <= WR_BURST;
              lock_id    <= gnt_id;
              beats_left <= bc_sel - BURST_WIDTH'(1);
            end else begin
              prio <= ~gnt_id;
            end
          end
        end
        WR_BURST: begin
          if (accept) begin
            beats_left <= beats_left - BURST_WIDTH'(1);
            if (beats_left == BURST_WIDTH'(1)) begin
              state <= IDLE;
              prio  <= ~lock_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head_id   = id_mem[rd_ptr];
  assign head_bc   = bc_mem[rd_ptr];
  assign beat_last = ((beat_cnt + BURST_WIDTH'(1)) == head_bc);
  assign pop       = s.readdatavalid & ~empty & beat_last;
  assign orphan    = s.readdatavalid & empty;

  // Tag FIFO pointers, return beat counter and registered read steering.
  always_ff @(posedge Clk_200) begin
    if (SoftReset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      beat_cnt         <= '0;
      rvalid0          <= 1'b0;
      rvalid1          <= 1'b0;
      err_orphan_rdata <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (s.readdatavalid && !empty)
        beat_cnt <= beat_last ? '0 : beat_cnt + BURST_WIDTH'(1);
      rvalid0 <= s.readdatavalid & ~empty & ~head_id;
      rvalid1 <= s.readdatavalid & ~empty &  head_id;
      if (orphan) err_orphan_rdata <= 1'b1;
    end
  end

  // Tag storage and return data pipeline carry no reset.
  always_ff @(posedge Clk_200) begin
    rdata_q <= s.readdata;
    if (push) begin
      id_mem[wr_ptr] <= gnt_id;
      bc_mem[wr_ptr] <= bc_sel;
    end
  end

  assign m0.readdata      = rdata_q;
  assign m1.readdata      = rdata_q;
  assign m0.readdatavalid = rvalid0;
  assign m1.readdatavalid = rvalid1;
  assign rd_outstanding   = count;

endmodule

// File: tb/tb_ddr4_bank_arbiter.sv
// Directed bench for ddr4_bank_arbiter: arbitration order, burst lock,
// read steering, FIFO full/concurrent push-pop, orphan beats and reset.
module tb_ddr4_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] rd_out;
  logic       err;
  int         checks = 0;
  int         errors = 0;

  ddr4_bank_arbiter_if m0_if ();
  ddr4_bank_arbiter_if m1_if ();
  ddr4_bank_arbiter_if s_if  ();

  ddr4_bank_arbiter dut (
    .Clk_200          (clk),
    .SoftReset        (rst),
    .m0               (m0_if),
    .m1               (m1_if),
    .s                (s_if),
    .rd_outstanding   (rd_out),
    .err_orphan_rdata (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0; m0_if.burstcount = 7'd1;
    m0_if.writedata = '0; m0_if.byteenable = '1;
    m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0; m1_if.burstcount = 7'd1;
    m1_if.writedata = '0; m1_if.byteenable = '1;
  endtask

  task automatic do_reset();
    clear_masters();
    s_if.waitrequest   = 1'b0;
    s_if.readdatavalid = 1'b0;
    s_if.readdata      = '0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [63:0] beat;
    logic        ws;
    rst = 1'b1;

    // Reset values, then a single m0 read issued with zero latency
    do_reset();
    #1;
    check("rst_m0_wait", 64'(m0_if.waitrequest), 64'd1);
    check("rst_m1_wait", 64'(m1_if.waitrequest), 64'd1);
    check("rst_s_read",  64'(s_if.read), 64'd0);
    check("rst_s_write", 64'(s_if.write), 64'd0);
    check("rst_m0_rv",   64'(m0_if.readdatavalid), 64'd0);
    check("rst_m1_rv",   64'(m1_if.readdatavalid), 64'd0);
    check("rst_rdout",   64'(rd_out), 64'd0);
    check("rst_err",     64'(err), 64'd0);
    m0_if.read = 1'b1; m0_if.address = 27'h100; m0_if.burstcount = 7'd1;
    #1;
    check("t1_s_read", 64'(s_if.read), 64'd1);
    check("t1_s_addr", 64'(s_if.address), 64'h100);
    check("t1_m0_wait", 64'(m0_if.waitrequest), 64'd0);
    tick();
    m0_if.read = 1'b0;
    #1 check("t1_rdout", 64'(rd_out), 64'd1);

    // Round-robin between two continuous single-beat readers
    do_reset();
    m0_if.read = 1'b1; m0_if.address = 27'h10;
    m1_if.read = 1'b1; m1_if.address = 27'h20;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("t2_grant%0d", i), 64'(s_if.address), (i % 2 == 0) ? 64'h10 : 64'h20);
      tick();
    end
    m0_if.read = 1'b0; m1_if.read = 1'b0;
    #1 check("t2_rdout4", 64'(rd_out), 64'd4);
    for (int i = 0; i < 4; i++) begin
      s_if.readdatavalid = 1'b1;
      s_if.readdata = 512'(64'hA0 + 64'(i));
      tick();
      check($sformatf("t2_m0_rv%0d", i), 64'(m0_if.readdatavalid), (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("t2_m1_rv%0d", i), 64'(m1_if.readdatavalid), (i % 2 == 1) ? 64'd1 : 64'd0);
      check($sformatf("t2_rdata%0d", i), m0_if.readdata[63:0], 64'hA0 + 64'(i));
    end
    s_if.readdatavalid = 1'b0;
    tick();
    check("t2_rdout0", 64'(rd_out), 64'd0);

    // m1 write burst of 4 holds the grant against an m0 read
    do_reset();
    m1_if.write = 1'b1; m1_if.address = 27'h40; m1_if.burstcount = 7'd4;
    m1_if.writedata = 512'(64'd1);
    #1;
    check("t3_s_write", 64'(s_if.write), 64'd1);
    check("t3_s_bc", 64'(s_if.burstcount), 64'd4);
    tick();
    beat = 64'd2;
    m0_if.read = 1'b1; m0_if.address = 27'h55; m0_if.burstcount = 7'd1;
    for (int i = 0; i < 6; i++) begin
      ws = (i % 2 == 0);
      s_if.waitrequest = ws;
      m1_if.writedata = 512'(beat);
      #1;
      check($sformatf("t3_wd%0d", i), s_if.writedata[63:0], beat);
      check($sformatf("t3_rd%0d", i), 64'(s_if.read), 64'd0);
      check($sformatf("t3_m0w%0d", i), 64'(m0_if.waitrequest), 64'd1);
      check($sformatf("t3_m1w%0d", i), 64'(m1_if.waitrequest), 64'(ws));
      tick();
      if (!ws) beat = beat + 64'd1;
    end
    m1_if.write = 1'b0;
    s_if.waitrequest = 1'b0;
    #1;
    check("t3_m0_read", 64'(s_if.read), 64'd1);
    check("t3_m0_addr", 64'(s_if.address), 64'h55);
    check("t3_m0_wait", 64'(m0_if.waitrequest), 64'd0);
    tick();

    // Fill the tag FIFO with 64 two-beat reads; writes still pass
    do_reset();
    m0_if.read = 1'b1; m0_if.burstcount = 7'd2;
    for (int i = 0; i < 64; i++) begin
      m0_if.address = 27'(i);
      tick();
    end
    #1;
    check("t4_rdout64", 64'(rd_out), 64'd64);
    check("t4_s_read", 64'(s_if.read), 64'd0);
    check("t4_m0_wait", 64'(m0_if.waitrequest), 64'd1);
    m1_if.write = 1'b1; m1_if.address = 27'h99; m1_if.burstcount = 7'd1;
    #1;
    check("t4_wr_gnt", 64'(s_if.write), 64'd1);
    check("t4_wr_addr", 64'(s_if.address), 64'h99);
    check("t4_m1_wait", 64'(m1_if.waitrequest), 64'd0);
    tick();
    m1_if.write = 1'b0; m0_if.read = 1'b0;
    #1 check("t4_rdout_keep", 64'(rd_out), 64'd64);

    // Return beats; the last one coincides with a new m1 read push at 63
    for (int j = 0; j < 4; j++) begin
      s_if.readdatavalid = 1'b1;
      s_if.readdata = 512'(64'hB0 + 64'(j));
      if (j == 3) begin
        m1_if.read = 1'b1; m1_if.address = 27'h77; m1_if.burstcount = 7'd1;
        #1;
        check("t5_push_rd", 64'(s_if.read), 64'd1);
        check("t5_push_addr", 64'(s_if.address), 64'h77);
      end
      tick();
      m1_if.read = 1'b0;
      check($sformatf("t5_m0_rv%0d", j), 64'(m0_if.readdatavalid), 64'd1);
      check($sformatf("t5_m1_rv%0d", j), 64'(m1_if.readdatavalid), 64'd0);
      check($sformatf("t5_rdata%0d", j), m0_if.readdata[63:0], 64'hB0 + 64'(j));
      check($sformatf("t5_rdout%0d", j), 64'(rd_out), (j == 0) ? 64'd64 : 64'd63);
    end
    s_if.readdatavalid = 1'b0;

    // Orphan beat, then reset in the middle of a write burst
    do_reset();
    s_if.readdatavalid = 1'b1;
    tick();
    s_if.readdatavalid = 1'b0;
    check("t6_orph_m0", 64'(m0_if.readdatavalid), 64'd0);
    check("t6_orph_m1", 64'(m1_if.readdatavalid), 64'd0);
    check("t6_err_set", 64'(err), 64'd1);
    m0_if.write = 1'b1; m0_if.address = 27'h30; m0_if.burstcount = 7'd4;
    tick();
    m1_if.write = 1'b1; m1_if.address = 27'h31; m1_if.burstcount = 7'd1;
    #1;
    check("t6_lock_addr", 64'(s_if.address), 64'h30);
    check("t6_lock_m1w", 64'(m1_if.waitrequest), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_if.write = 1'b0;
    #1;
    check("t6_err_clr", 64'(err), 64'd0);
    check("t6_idle_wr", 64'(s_if.write), 64'd1);
    check("t6_idle_addr", 64'(s_if.address), 64'h31);
    check("t6_idle_m1w", 64'(m1_if.waitrequest), 64'd0);
    tick();
    clear_masters();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
